// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register with load-data extraction and
//               writeback selection for a 5-stage RV32I core. Drives the
//               register-file write port, the WB forwarding value and a
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int RET_CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic                 RegWrite_in,
  input  logic [1:0]           wb_sel_in,
  input  logic [2:0]           funct3_in,
  input  logic [4:0]           rd_in,
  input  logic [31:0]          alu_result_in,
  input  logic [31:0]          mem_read_data_in,
  input  logic [31:0]          pc_plus4_in,
  output logic                 valid_out,
  output logic                 RegWrite_out,
  output logic [4:0]           rd_out,
  output logic [31:0]          wb_data_out,
  output logic                 misaligned_out,
  output logic [RET_CNT_W-1:0] retired_count
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_WB_ALU  = 2'b00;
  localparam logic [1:0] c_WB_LOAD = 2'b01;
  localparam logic [1:0] c_WB_PC4  = 2'b10;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  localparam logic [RET_CNT_W-1:0] c_CNT_ONE = {{(RET_CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic        w_is_load;
  logic        w_misaligned;
  logic [31:0] w_wb_data;
  logic        w_reg_write;
  logic        w_retire;

  assign w_lane    = alu_result_in[1:0];
  assign w_is_load = (wb_sel_in == c_WB_LOAD);

  // Pick the addressed byte lane out of the aligned memory word
  always_comb begin
    w_byte = 8'h00;
    case (w_lane)
      2'd0:    w_byte = mem_read_data_in[7:0];
      2'd1:    w_byte = mem_read_data_in[15:8];
      2'd2:    w_byte = mem_read_data_in[23:16];
      default: w_byte = mem_read_data_in[31:24];
    endcase
  end

  // Pick the addressed halfword; only lane[1] matters, lane[0] flags misalignment
  always_comb begin
    w_half = w_lane[1] ? mem_read_data_in[31:16] : mem_read_data_in[15:0];
  end

  // Sign- or zero-extend the selected lane according to the load width
  always_comb begin
    w_load_data = 32'h0000_0000;
    case (funct3_in)
      c_F3_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_F3_LBU: w_load_data = {24'h00_0000, w_byte};
      c_F3_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      c_F3_LHU: w_load_data = {16'h0000, w_half};
      c_F3_LW:  w_load_data = mem_read_data_in;
      default:  w_load_data = 32'h0000_0000;
    endcase
  end

  // Alignment check applies only to real load instructions
  always_comb begin
    w_misaligned = 1'b0;
    if (valid_in && w_is_load) begin
      case (funct3_in)
        c_F3_LH, c_F3_LHU: w_misaligned = w_lane[0];
        c_F3_LW:           w_misaligned = (w_lane != 2'b00);
        default:           w_misaligned = 1'b0;
      endcase
    end
  end

  // Writeback source select; the reserved code behaves like the ALU path
  always_comb begin
    w_wb_data = alu_result_in;
    case (wb_sel_in)
      c_WB_LOAD: w_wb_data = w_load_data;
      c_WB_PC4:  w_wb_data = pc_plus4_in;
      default:   w_wb_data = alu_result_in;
    endcase
  end

  // Write enable is suppressed for bubbles, x0 and faulting loads
  always_comb begin
    w_reg_write = valid_in & RegWrite_in & (rd_in != 5'd0) & ~w_misaligned;
    w_retire    = valid_in & ~w_misaligned;
  end

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  logic                 r_valid;
  logic                 r_reg_write;
  logic [4:0]           r_rd;
  logic [31:0]          r_wb_data;
  logic                 r_misaligned;
  logic [RET_CNT_W-1:0] r_retired_count;

  // Pipeline register: reset, then flush bubble, then stall hold, else capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_wb_data    <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_wb_data    <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else if (!stall) begin
      r_valid      <= valid_in;
      r_reg_write  <= w_reg_write;
      r_rd         <= rd_in;
      r_wb_data    <= w_wb_data;
      r_misaligned <= w_misaligned;
    end
  end

  // Retired-instruction counter; advances only on a capture that retires
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_count <= '0;
    end else if (!flush && !stall && w_retire) begin
      r_retired_count <= r_retired_count + c_CNT_ONE;
    end
  end

  assign valid_out      = r_valid;
  assign RegWrite_out   = r_reg_write;
  assign rd_out         = r_rd;
  assign wb_data_out    = r_wb_data;
  assign misaligned_out = r_misaligned;
  assign retired_count  = r_retired_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Scoreboard bench for mem_wb_stage. Stimulus pushes the
//               hand-computed expected WB state for each clock; a monitor pops
//               and compares after every rising edge. A 4-bit counter instance
//               shares the stimulus to exercise counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in, RegWrite_in;
  logic [1:0]  wb_sel_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_result_in, mem_read_data_in, pc_plus4_in;

  logic        valid_out, RegWrite_out, misaligned_out;
  logic [4:0]  rd_out;
  logic [31:0] wb_data_out;
  logic [63:0] retired_count;

  logic        s_valid, s_rw, s_mis;
  logic [4:0]  s_rd;
  logic [31:0] s_data;
  logic [3:0]  s_count;

  always #5 clk = ~clk;

  mem_wb_stage #(.RET_CNT_W(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_in(valid_in), .RegWrite_in(RegWrite_in), .wb_sel_in(wb_sel_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .alu_result_in(alu_result_in),
    .mem_read_data_in(mem_read_data_in), .pc_plus4_in(pc_plus4_in),
    .valid_out(valid_out), .RegWrite_out(RegWrite_out), .rd_out(rd_out),
    .wb_data_out(wb_data_out), .misaligned_out(misaligned_out),
    .retired_count(retired_count)
  );

  mem_wb_stage #(.RET_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_in(valid_in), .RegWrite_in(RegWrite_in), .wb_sel_in(wb_sel_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .alu_result_in(alu_result_in),
    .mem_read_data_in(mem_read_data_in), .pc_plus4_in(pc_plus4_in),
    .valid_out(s_valid), .RegWrite_out(s_rw), .rd_out(s_rd),
    .wb_data_out(s_data), .misaligned_out(s_mis),
    .retired_count(s_count)
  );

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        m;
    logic [63:0] c;
    logic [3:0]  c4;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so one result appears after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "valid_out", {63'd0, valid_out}, {63'd0, e.v});
        chk(e.nm, "RegWrite_out", {63'd0, RegWrite_out}, {63'd0, e.rw});
        chk(e.nm, "rd_out", {59'd0, rd_out}, {59'd0, e.rd});
        chk(e.nm, "wb_data_out", {32'd0, wb_data_out}, {32'd0, e.d});
        chk(e.nm, "misaligned_out", {63'd0, misaligned_out}, {63'd0, e.m});
        chk(e.nm, "retired_count", retired_count, e.c);
        chk(e.nm, "retired_count4", {60'd0, s_count}, {60'd0, e.c4});
      end
    end
  end

  // Drive one cycle of inputs at the falling edge
  task automatic drive(input logic r, st, fl, v, rw, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, mem, pc);
    @(negedge clk);
    rst = r; stall = st; flush = fl; valid_in = v; RegWrite_in = rw;
    wb_sel_in = sel; funct3_in = f3; rd_in = rd;
    alu_result_in = alu; mem_read_data_in = mem; pc_plus4_in = pc;
  endtask

  // Expected WB state after the edge that follows the last drive
  task automatic expect_wb(input string nm, input logic v, rw, input logic [4:0] rd,
                           input logic [31:0] d, input logic m, input logic [63:0] c);
    exp_t e;
    e.nm = nm; e.v = v; e.rw = rw; e.rd = rd; e.d = d; e.m = m; e.c = c;
    e.c4 = c[3:0];
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; RegWrite_in = 1'b0;
    wb_sel_in = 2'b00; funct3_in = 3'b000; rd_in = 5'd0;
    alu_result_in = 32'h0; mem_read_data_in = 32'h0; pc_plus4_in = 32'h0;

    // Reset for two cycles, then idle bubbles
    drive(1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_wb("reset0", 0, 0, 5'd0, 32'h0, 0, 64'd0);
    drive(1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_wb("reset1", 0, 0, 5'd0, 32'h0, 0, 64'd0);
    drive(0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_wb("idle", 0, 0, 5'd0, 32'h0, 0, 64'd0);

    // Byte loads from lane 3
    drive(0, 0, 0, 1, 1, 2'b01, 3'b000, 5'd5, 32'h0000_0103, 32'h80FF_1234, 32'h0);
    expect_wb("lb", 1, 1, 5'd5, 32'hFFFF_FF80, 0, 64'd1);
    drive(0, 0, 0, 1, 1, 2'b01, 3'b100, 5'd5, 32'h0000_0103, 32'h80FF_1234, 32'h0);
    expect_wb("lbu", 1, 1, 5'd5, 32'h0000_0080, 0, 64'd2);

    // Halfword and word loads, aligned and misaligned
    drive(0, 0, 0, 1, 1, 2'b01, 3'b001, 5'd6, 32'h0000_0101, 32'h1234_8765, 32'h0);
    expect_wb("lh_mis", 1, 0, 5'd6, 32'hFFFF_8765, 1, 64'd2);
    drive(0, 0, 0, 1, 1, 2'b01, 3'b101, 5'd6, 32'h0000_0102, 32'h1234_8765, 32'h0);
    expect_wb("lhu", 1, 1, 5'd6, 32'h0000_1234, 0, 64'd3);
    drive(0, 0, 0, 1, 1, 2'b01, 3'b010, 5'd7, 32'h0000_0102, 32'h1234_8765, 32'h0);
    expect_wb("lw_mis", 1, 0, 5'd7, 32'h1234_8765, 1, 64'd3);
    drive(0, 0, 0, 1, 1, 2'b01, 3'b010, 5'd7, 32'h0000_0100, 32'h1234_8765, 32'h0);
    expect_wb("lw", 1, 1, 5'd7, 32'h1234_8765, 0, 64'd4);

    // ALU to x0, reserved select, JAL link, unsupported load width
    drive(0, 0, 0, 1, 1, 2'b00, 3'b001, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    expect_wb("alu_x0", 1, 0, 5'd0, 32'hDEAD_BEEF, 0, 64'd5);
    drive(0, 0, 0, 1, 1, 2'b11, 3'b010, 5'd8, 32'h0000_0055, 32'hAAAA_AAAA, 32'h0000_0099);
    expect_wb("sel11", 1, 1, 5'd8, 32'h0000_0055, 0, 64'd6);
    drive(0, 0, 0, 1, 1, 2'b10, 3'b000, 5'd1, 32'h0000_1000, 32'h0, 32'h0000_0044);
    expect_wb("jal", 1, 1, 5'd1, 32'h0000_0044, 0, 64'd7);
    drive(0, 0, 0, 1, 1, 2'b01, 3'b011, 5'd2, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0);
    expect_wb("ld_f3_011", 1, 1, 5'd2, 32'h0000_0000, 0, 64'd8);

    // Bubble carrying a would-be misaligned load: no flag, no write, no retire
    drive(0, 0, 0, 0, 1, 2'b01, 3'b001, 5'd3, 32'h0000_0101, 32'h1234_8765, 32'h0);
    expect_wb("bubble", 0, 0, 5'd3, 32'hFFFF_8765, 0, 64'd8);

    // Capture, then hold through three stalled cycles with changing inputs
    drive(0, 0, 0, 1, 1, 2'b00, 3'b000, 5'd9, 32'h1111_1111, 32'h0, 32'h0);
    expect_wb("cap", 1, 1, 5'd9, 32'h1111_1111, 0, 64'd9);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 1, 2'b00, 3'b000, 5'd10 + 5'(i), 32'h2222_0000 + 32'(i), 32'h0, 32'h0);
      expect_wb("stall", 1, 1, 5'd9, 32'h1111_1111, 0, 64'd9);
    end
    drive(0, 1, 1, 1, 1, 2'b00, 3'b000, 5'd12, 32'h3333_3333, 32'h0, 32'h0);
    expect_wb("stall_flush", 0, 0, 5'd0, 32'h0, 0, 64'd9);

    // Reset asserted while stalled clears everything
    drive(0, 0, 0, 1, 1, 2'b00, 3'b000, 5'd4, 32'h0000_2222, 32'h0, 32'h0);
    expect_wb("cap2", 1, 1, 5'd4, 32'h0000_2222, 0, 64'd10);
    drive(1, 1, 0, 1, 1, 2'b00, 3'b000, 5'd4, 32'h0000_2222, 32'h0, 32'h0);
    expect_wb("rst_stall", 0, 0, 5'd0, 32'h0, 0, 64'd0);

    // Seventeen retirements: the 4-bit counter wraps to 1
    for (int i = 1; i <= 17; i++) begin
      drive(0, 0, 0, 1, 1, 2'b00, 3'b000, 5'd1, 32'(i), 32'h0, 32'h0);
      expect_wb("retire", 1, 1, 5'd1, 32'(i), 0, 64'(i));
    end

    drive(0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_wb("final_idle", 0, 0, 5'd0, 32'h0, 0, 64'd17);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
